// File: rtl/c_damq_credit_tracker_pkg.sv
// rtl/c_damq_credit_tracker_pkg.sv - shared reset-type encodings and counter sizing helpers
package c_damq_credit_tracker_pkg;

  localparam int RESET_TYPE_ASYNC = 0;
  localparam int RESET_TYPE_SYNC  = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bits needed to hold 0..max_count, never less than one bit.
  function automatic int cnt_width(input int max_count);
    int w;
    w = clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/c_damq_credit_tracker_fifo.sv
// rtl/c_damq_credit_tracker_fifo.sv - occupancy tracker for the shared credit pool
//   clk, reset (active-low), active (clock enable)
//   push / pop        : one entry taken / returned this cycle
//   full, almost_full : no free entry / exactly one free entry
module c_fifo_tracker
  import c_damq_credit_tracker_pkg::*;
#(
  parameter int depth         = 8,
  parameter bit enable_bypass = 1'b0,
  parameter int reset_type    = RESET_TYPE_ASYNC
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic almost_full
);

  localparam int cw = cnt_width(depth);

  logic [cw-1:0] count_q;
  logic [cw-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  // With bypass, a pop against an empty tracker is legal when a push lands
  // in the same cycle (the entry passes straight through).
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ((count_q != '0) | (enable_bypass & push));

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + cw'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - cw'(1);
    end
  end

  generate
    if (reset_type == RESET_TYPE_SYNC) begin : g_sync_reset
      always_ff @(posedge clk) begin
        if (!reset) begin
          count_q <= '0;
        end else if (active) begin
          count_q <= count_d;
        end
      end
    end else begin : g_async_reset
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_q <= '0;
        end else if (active) begin
          count_q <= count_d;
        end
      end
    end
  endgenerate

  // A zero-depth pool is permanently full and never almost full.
  assign full        = (count_q == cw'(depth));
  assign almost_full = (depth != 0) && (count_q == cw'(depth - 1));

endmodule

// File: rtl/c_damq_credit_tracker.sv
// rtl/c_damq_credit_tracker.sv - per-queue credit tracking for a downstream DAMQ buffer
//   clk, reset (async, active-low), active (clock enable for all state)
//   debit_valid / debit_sel_qu : flit sent downstream to a one-hot queue
//   cred_valid / cred_sel_qu   : credit returned for a one-hot queue (registered once)
//   empty_qu, almost_full_qu, full_qu : per-queue status from registered state
//   idle      : every queue empty and no credit waiting in the input register
//   errors_qu : [2q] spurious credit, [2q+1] debit while full
module c_damq_credit_tracker
  import c_damq_credit_tracker_pkg::*;
#(
  parameter int num_queues          = 4,
  parameter int num_slots           = 32,
  parameter bit enable_reservations = 1'b0,
  parameter int reset_type          = RESET_TYPE_ASYNC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    debit_valid,
  input  logic [num_queues-1:0]   debit_sel_qu,
  input  logic                    cred_valid,
  input  logic [num_queues-1:0]   cred_sel_qu,
  output logic [num_queues-1:0]   empty_qu,
  output logic [num_queues-1:0]   almost_full_qu,
  output logic [num_queues-1:0]   full_qu,
  output logic                    idle,
  output logic [num_queues*2-1:0] errors_qu
);

  localparam int num_shared_slots = enable_reservations ? (num_slots - num_queues) : num_slots;
  localparam int num_queue_slots  = enable_reservations ? (1 + num_shared_slots) : num_slots;
  localparam int occ_w            = cnt_width(num_queue_slots);

  logic                  cred_valid_q;
  logic [num_queues-1:0] cred_sel_qu_q;
  logic [num_queues-1:0] debit_shared_qu;
  logic [num_queues-1:0] credit_shared_qu;
  logic                  shared_full;
  logic                  shared_almost_full;

  // Returned credits are retimed once before they touch the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cred_valid_q  <= 1'b0;
      cred_sel_qu_q <= '0;
    end else if (active) begin
      cred_valid_q  <= cred_valid;
      cred_sel_qu_q <= cred_sel_qu;
    end
  end

  c_fifo_tracker #(
    .depth        (num_shared_slots),
    .enable_bypass(1'b0),
    .reset_type   (reset_type)
  ) u_shared (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .push       (|debit_shared_qu),
    .pop        (|credit_shared_qu),
    .full       (shared_full),
    .almost_full(shared_almost_full)
  );

  generate
    for (genvar q = 0; q < num_queues; q++) begin : g_queue
      logic [occ_w-1:0] occ;
      logic [occ_w-1:0] occ_next;
      logic             occ_nz;
      logic             deb;
      logic             cred;
      logic             deb_ok;
      logic             cred_ok;

      assign occ_nz = (occ != '0);
      assign deb    = active & debit_valid & debit_sel_qu[q];
      assign cred   = active & cred_valid_q & cred_sel_qu_q[q];

      // An idle queue still owns its reserved slot, so it is only full when it
      // already holds that slot and the shared pool is exhausted.
      assign full_qu[q]        = enable_reservations ? (occ_nz & shared_full) : shared_full;
      assign almost_full_qu[q] = (enable_reservations && !occ_nz) ? shared_full : shared_almost_full;
      assign empty_qu[q]       = ~occ_nz;

      assign errors_qu[2*q]   = cred & ~occ_nz;
      assign errors_qu[2*q+1] = deb & full_qu[q];

      assign deb_ok  = deb & ~full_qu[q];
      assign cred_ok = cred & occ_nz;

      // The first entry of a queue sits in its reserved slot and the last one
      // to leave frees it. A debit and credit hitting the same queue cancel.
      assign debit_shared_qu[q]  = deb_ok & ~cred_ok & (~enable_reservations | occ_nz);
      assign credit_shared_qu[q] = cred_ok & ~deb_ok & (~enable_reservations | (occ > occ_w'(1)));

      always_comb begin
        occ_next = occ;
        if (deb_ok && !cred_ok) begin
          occ_next = occ + occ_w'(1);
        end else if (cred_ok && !deb_ok) begin
          occ_next = occ - occ_w'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          occ <= '0;
        end else if (active) begin
          occ <= occ_next;
        end
      end
    end
  endgenerate

  assign idle = (&empty_qu) & ~cred_valid_q;

endmodule

// File: tb/tb_c_damq_credit_tracker.sv
// tb/tb_c_damq_credit_tracker.sv - self-checking bench for c_damq_credit_tracker
module tb_c_damq_credit_tracker;

  localparam int NQ     = 4;
  localparam int SHARED = 4;

  typedef struct {
    string      tag;
    logic [3:0] empty;
    logic [3:0] full;
    logic [3:0] af;
    logic       idle;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b0;
  logic       debit_valid = 1'b0;
  logic [3:0] debit_sel_qu = '0;
  logic       cred_valid = 1'b0;
  logic [3:0] cred_sel_qu = '0;
  logic [3:0] empty_qu;
  logic [3:0] almost_full_qu;
  logic [3:0] full_qu;
  logic       idle;
  logic [7:0] errors_qu;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb[$];

  int m_occ[NQ];
  int m_used;
  bit m_pv;
  int m_pq;

  c_damq_credit_tracker #(
    .num_queues         (4),
    .num_slots          (8),
    .enable_reservations(1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .active        (active),
    .debit_valid   (debit_valid),
    .debit_sel_qu  (debit_sel_qu),
    .cred_valid    (cred_valid),
    .cred_sel_qu   (cred_sel_qu),
    .empty_qu      (empty_qu),
    .almost_full_qu(almost_full_qu),
    .full_qu       (full_qu),
    .idle          (idle),
    .errors_qu     (errors_qu)
  );

  always #5 clk = ~clk;

  function automatic bit m_full(input int q);
    return (m_occ[q] != 0) && (m_used == SHARED);
  endfunction

  function automatic bit m_af(input int q);
    return (m_occ[q] == 0) ? (m_used == SHARED) : (m_used == SHARED - 1);
  endfunction

  function automatic exp_t m_flags(input string tag);
    exp_t e;
    e.tag  = tag;
    e.err  = '0;
    e.idle = !m_pv;
    for (int q = 0; q < NQ; q++) begin
      e.empty[q] = (m_occ[q] == 0);
      e.full[q]  = m_full(q);
      e.af[q]    = m_af(q);
      if (m_occ[q] != 0) e.idle = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".empty"}, {4'b0, empty_qu}, {4'b0, e.empty});
    chk({e.tag, ".full"},  {4'b0, full_qu},  {4'b0, e.full});
    chk({e.tag, ".af"},    {4'b0, almost_full_qu}, {4'b0, e.af});
    chk({e.tag, ".idle"},  {7'b0, idle}, {7'b0, e.idle});
    chk({e.tag, ".err"},   errors_qu, e.err);
  endtask

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) m_occ[q] = 0;
    m_used = 0;
    m_pv   = 1'b0;
    m_pq   = 0;
  endtask

  // Reset is applied mid-cycle; outputs must clear without any clock edge.
  task automatic do_reset(input string tag);
    exp_t e;
    reset       = 1'b0;
    active      = 1'b0;
    debit_valid = 1'b0;
    cred_valid  = 1'b0;
    model_reset();
    e = m_flags(tag);
    sb.push_back(e);
    #1;
    check_front();
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    active = 1'b1;
  endtask

  task automatic step(input bit dv, input int dq, input bit cv, input int cq,
                      input bit act, input string tag);
    exp_t e;
    bit   deb_ok, cr_ok, d_sh, c_sh;
    @(negedge clk);
    debit_valid  = dv;
    debit_sel_qu = dv ? 4'(1 << dq) : 4'b0;
    cred_valid   = cv;
    cred_sel_qu  = cv ? 4'(1 << cq) : 4'b0;
    active       = act;
    e = m_flags(tag);
    if (act) begin
      if (m_pv && m_occ[m_pq] == 0) e.err[2*m_pq] = 1'b1;
      if (dv && m_full(dq)) e.err[2*dq+1] = 1'b1;
    end
    sb.push_back(e);
    #1;
    check_front();
    if (act) begin
      deb_ok = dv && !m_full(dq);
      cr_ok  = m_pv && (m_occ[m_pq] != 0);
      if (!(deb_ok && cr_ok && dq == m_pq)) begin
        d_sh = deb_ok && (m_occ[dq] != 0);
        c_sh = cr_ok && (m_occ[m_pq] >= 2);
        if (deb_ok) m_occ[dq]++;
        if (cr_ok) m_occ[m_pq]--;
        m_used = m_used + int'(d_sh) - int'(c_sh);
      end
      m_pv = cv;
      m_pq = cq;
    end
  endtask

  initial begin
    model_reset();
    do_reset("por");
    step(0, 0, 0, 0, 1, "idle_after_reset");

    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, "fill_q0");
    step(1, 0, 0, 0, 1, "overflow_q0");
    step(0, 0, 0, 0, 1, "q0_full_hold");

    step(0, 0, 1, 0, 1, "cred_q0_sent");
    step(0, 0, 0, 0, 1, "cred_q0_captured");
    step(0, 0, 0, 0, 1, "cred_q0_applied");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, "cred_q0_stream");
    step(0, 0, 0, 0, 1, "cred_q0_last_pending");
    step(0, 0, 0, 0, 1, "cred_q0_drained");

    do_reset("reset_mix");
    step(1, 0, 0, 0, 1, "deb_q0");
    step(1, 1, 0, 0, 1, "deb_q1_a");
    step(1, 1, 0, 0, 1, "deb_q1_b");
    step(0, 0, 1, 1, 1, "cred_q1");
    step(1, 0, 0, 0, 1, "deb_q0_cred_q1");
    step(0, 0, 0, 0, 1, "mix_result");

    step(0, 0, 1, 2, 1, "spur_q2_sent");
    step(0, 0, 0, 0, 1, "spur_q2_err");
    step(0, 0, 0, 0, 1, "spur_q2_after");

    step(0, 0, 1, 1, 1, "cred_q1_before_gate");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "inactive_deb");
    step(0, 0, 0, 0, 1, "gate_released");
    step(0, 0, 0, 0, 1, "gate_settled");

    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 1, "fill_q3");
    step(1, 2, 0, 0, 1, "fill_q2");
    step(1, 1, 0, 0, 1, "fill_q1");
    step(1, 2, 0, 0, 1, "q2_full");
    step(0, 0, 0, 0, 1, "pool_full");

    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 9) != 0), "random");
    end

    do_reset("reset_pre_mid");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, "deb_q0_mid");
    step(0, 0, 1, 0, 1, "pend_cred_mid");
    do_reset("mid_reset");
    step(0, 0, 0, 0, 1, "after_mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
